// File: rtl/floating_point_accumulator.sv
// floating_point_adder
//   Combinational IEEE-754 style adder/subtractor for a sign/exponent/mantissa
//   format of configurable width. Subnormals are handled fully; any NaN result
//   is the canonical quiet NaN (sign 1, exponent all ones, mantissa MSB set).
//   Ports:
//     a_i, b_i                  operands
//     subtract_i                1: a - b, 0: a + b
//     result_o                  rounded sum
//     underflow_flag_o          result is a nonzero subnormal
//     overflow_flag_o           finite operands produced an out-of-range sum
//     invalid_operation_flag_o  inf - inf, or a signalling NaN operand
//
// floating_point_accumulator
//   Packet reduction stage: sums a valid/ready stream of floats into a running
//   register and, on the last beat, presents the total with a saturating beat
//   count and sticky adder flags.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     in_valid/in_ready               input beat handshake
//     in_data, in_subtract, in_last   operand, add/subtract select, packet end
//     out_valid/out_ready             result handshake
//     out_data, out_count             packet sum, beats in packet
//     out_underflow/overflow/invalid  sticky flags for the packet

module floating_point_adder #(
  parameter int unsigned EXPONENT_WIDTH                = 8,
  parameter int unsigned MANTISSA_WIDTH                = 23,
  parameter int unsigned ROUND_TO_NEAREST_TIES_TO_EVEN = 1
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a_i,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b_i,
  input  logic                                   subtract_i,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result_o,
  output logic                                   underflow_flag_o,
  output logic                                   overflow_flag_o,
  output logic                                   invalid_operation_flag_o
);

  localparam int unsigned EW   = EXPONENT_WIDTH;
  localparam int unsigned MW   = MANTISSA_WIDTH;
  localparam int unsigned FW   = EW + MW + 1;
  localparam int unsigned W    = MW + 1;          // significand incl. hidden bit
  localparam int unsigned XW   = W + 3;           // plus guard, round, sticky
  localparam int unsigned RW   = W + 1;
  localparam int unsigned SW   = $clog2(XW + 1);
  localparam int unsigned EXW  = EW + 2;
  localparam int unsigned EMAX = (1 << EW) - 1;

  localparam logic [FW-1:0] QNAN = {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  function automatic logic [EXW-1:0] eff_exp(input logic [EW-1:0] e);
    // Subnormals share the exponent of the smallest normal.
    return (e == '0) ? EXW'(1) : EXW'(e);
  endfunction

  logic           sa, sb;
  logic [EW-1:0]  ea, eb;
  logic [MW-1:0]  ma, mb;
  logic           a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;

  assign sa = a_i[FW-1];
  assign sb = b_i[FW-1] ^ subtract_i;
  assign ea = a_i[FW-2:MW];
  assign eb = b_i[FW-2:MW];
  assign ma = a_i[MW-1:0];
  assign mb = b_i[MW-1:0];

  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);
  assign a_snan = a_nan && !ma[MW-1];
  assign b_snan = b_nan && !mb[MW-1];
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);

  logic           swap, sl, ss, eff_sub, rs, inc, zero_res;
  logic [EXW-1:0] el, es, diff, en, ef;
  logic [W-1:0]   gl, gs;
  logic [SW-1:0]  sh;
  logic [XW-1:0]  xl, xs, aligned, lost, norm;
  logic [XW:0]    sum;
  logic [RW-1:0]  rnd;
  logic [MW-1:0]  ff;
  int unsigned    lz, lsh;
  logic [FW-1:0]  res;
  logic           ovf, unf, inv;

  always_comb begin
    // Order operands so the larger magnitude is on the left; the aligned
    // subtraction below then never goes negative.
    swap = {eb, mb} > {ea, ma};
    sl   = swap ? sb : sa;
    ss   = swap ? sa : sb;
    el   = eff_exp(swap ? eb : ea);
    es   = eff_exp(swap ? ea : eb);
    gl   = swap ? {eb != '0, mb} : {ea != '0, ma};
    gs   = swap ? {ea != '0, ma} : {eb != '0, mb};

    diff = el - es;
    sh   = (32'(diff) > XW) ? SW'(XW) : SW'(diff);
    xl   = {gl, 3'b000};
    xs   = {gs, 3'b000};
    lost = xs & ~({XW{1'b1}} << sh);
    aligned    = xs >> sh;
    aligned[0] = aligned[0] | (|lost);

    eff_sub = sl ^ ss;
    sum = eff_sub ? ({1'b0, xl} - {1'b0, aligned})
                  : ({1'b0, xl} + {1'b0, aligned});

    lz  = XW;
    lsh = 0;
    if (sum[XW]) begin
      norm    = sum[XW:1];
      norm[0] = norm[0] | sum[0];
      en      = el + EXW'(1);
    end else begin
      for (int unsigned i = 0; i < XW; i++) begin
        if (sum[i]) lz = XW - 1 - i;
      end
      // Stop normalising at the minimum exponent; the result is then subnormal.
      lsh  = (lz > 32'(el) - 1) ? 32'(el) - 1 : lz;
      norm = sum[XW-1:0] << lsh;
      en   = el - EXW'(lsh);
    end

    inc = (ROUND_TO_NEAREST_TIES_TO_EVEN != 0) && norm[2] &&
          (norm[1] || norm[0] || norm[3]);
    rnd = {1'b0, norm[XW-1:3]} + RW'(inc);
    if (rnd[W]) begin
      ef = en + EXW'(1);
      ff = '0;
    end else begin
      // A subnormal that rounds up into the hidden bit becomes the min normal.
      ef = rnd[W-1] ? en : '0;
      ff = rnd[MW-1:0];
    end

    zero_res = (sum == '0);
    rs       = (zero_res && eff_sub) ? 1'b0 : sl;

    ovf = 1'b0;
    unf = 1'b0;
    inv = 1'b0;
    if (a_nan || b_nan) begin
      res = QNAN;
      inv = a_snan || b_snan;
    end else if (a_inf && b_inf && (sa != sb)) begin
      res = QNAN;
      inv = 1'b1;
    end else if (a_inf) begin
      res = {sa, {EW{1'b1}}, {MW{1'b0}}};
    end else if (b_inf) begin
      res = {sb, {EW{1'b1}}, {MW{1'b0}}};
    end else if (32'(ef) >= EMAX) begin
      ovf = 1'b1;
      res = (ROUND_TO_NEAREST_TIES_TO_EVEN != 0) ?
            {rs, {EW{1'b1}}, {MW{1'b0}}} :
            {rs, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
    end else begin
      res = {rs, ef[EW-1:0], ff};
      unf = (ef == '0) && (ff != '0);
    end
  end

  assign result_o                 = res;
  assign underflow_flag_o         = unf;
  assign overflow_flag_o          = ovf;
  assign invalid_operation_flag_o = inv;

endmodule

module floating_point_accumulator #(
  parameter int unsigned EXPONENT_WIDTH                = 8,
  parameter int unsigned MANTISSA_WIDTH                = 23,
  parameter int unsigned ROUND_TO_NEAREST_TIES_TO_EVEN = 1,
  parameter int unsigned COUNT_WIDTH                   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_data,
  input  logic                                   in_subtract,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_data,
  output logic [COUNT_WIDTH-1:0]                 out_count,
  output logic                                   out_underflow,
  output logic                                   out_overflow,
  output logic                                   out_invalid
);

  localparam int unsigned FW = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                 state;
  logic [FW-1:0]          acc_q, acc_d, sum;
  logic [COUNT_WIDTH-1:0] count_q, count_d, count_inc;
  logic                   uf_q, uf_d, of_q, of_d, inv_q, inv_d;
  logic                   add_uf, add_of, add_inv;
  logic                   out_valid_q, out_valid_d;
  logic [FW-1:0]          out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                   out_uf_q, out_uf_d, out_of_q, out_of_d;
  logic                   out_inv_q, out_inv_d;
  logic                   beat, take;

  floating_point_adder #(
    .EXPONENT_WIDTH               (EXPONENT_WIDTH),
    .MANTISSA_WIDTH               (MANTISSA_WIDTH),
    .ROUND_TO_NEAREST_TIES_TO_EVEN(ROUND_TO_NEAREST_TIES_TO_EVEN)
  ) u_adder (
    .a_i                     (acc_q),
    .b_i                     (in_data),
    .subtract_i              (in_subtract),
    .result_o                (sum),
    .underflow_flag_o        (add_uf),
    .overflow_flag_o         (add_of),
    .invalid_operation_flag_o(add_inv)
  );

  // HOLD is fully determined by the output handshake, so it is decoded
  // rather than stored; a stored copy could only lag out_ready by a cycle.
  assign state    = (out_valid_q && !out_ready) ? HOLD : ACCUM;
  assign in_ready = (state == ACCUM);
  assign beat     = in_valid && in_ready;
  assign take     = out_valid_q && out_ready;

  assign count_inc = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    uf_d        = uf_q;
    of_d        = of_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_uf_d    = out_uf_q;
    out_of_d    = out_of_q;
    out_inv_d   = out_inv_q;

    if (take) out_valid_d = 1'b0;

    if (beat) begin
      if (in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = sum;
        out_count_d = count_inc;
        out_uf_d    = uf_q | add_uf;
        out_of_d    = of_q | add_of;
        out_inv_d   = inv_q | add_inv;
        acc_d       = '0;
        count_d     = '0;
        uf_d        = 1'b0;
        of_d        = 1'b0;
        inv_d       = 1'b0;
      end else begin
        acc_d   = sum;
        count_d = count_inc;
        uf_d    = uf_q | add_uf;
        of_d    = of_q | add_of;
        inv_d   = inv_q | add_inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      count_q     <= '0;
      uf_q        <= 1'b0;
      of_q        <= 1'b0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_uf_q    <= 1'b0;
      out_of_q    <= 1'b0;
      out_inv_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      uf_q        <= uf_d;
      of_q        <= of_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_uf_q    <= out_uf_d;
      out_of_q    <= out_of_d;
      out_inv_q   <= out_inv_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_count     = out_count_q;
  assign out_underflow = out_uf_q;
  assign out_overflow  = out_of_q;
  assign out_invalid   = out_inv_q;

endmodule

// File: tb/tb_floating_point_accumulator.sv
// Bench for floating_point_accumulator (E8M23, 4-bit beat counter so that
// saturation is reachable in a short packet).
module tb_floating_point_accumulator;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_subtract, in_last;
  logic [31:0]   in_data;
  logic          out_valid, out_ready;
  logic [31:0]   out_data;
  logic [CW-1:0] out_count;
  logic          out_underflow, out_overflow, out_invalid;

  always #5 clk = ~clk;

  floating_point_accumulator #(
    .EXPONENT_WIDTH               (8),
    .MANTISSA_WIDTH               (23),
    .ROUND_TO_NEAREST_TIES_TO_EVEN(1),
    .COUNT_WIDTH                  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_subtract  (in_subtract),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_underflow(out_underflow),
    .out_overflow (out_overflow),
    .out_invalid  (out_invalid)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected results, flags packed as {underflow, overflow, invalid}.
  typedef struct {
    logic [31:0]   data;
    logic [CW-1:0] count;
    logic [2:0]    flags;
  } res_t;

  res_t        exp_q[$];
  logic        m_ov = 1'b0;       // expected out_valid
  logic        held = 1'b0;
  logic [31:0] held_data = '0;

  // Reference model for random packets: real arithmetic, rounded to single.
  bit          use_model = 0;
  real         m_acc = 0.0;
  int unsigned m_cnt = 0;

  function automatic real f2r(input logic [31:0] f);
    if (f[30:0] == '0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] b;
    logic [52:0] m;
    logic [24:0] t;
    logic        up;
    int          e;
    b = $realtobits(x);
    if (b[62:0] == '0) return {b[63], 31'b0};
    e  = int'(b[62:52]) - 896;
    m  = {1'b1, b[51:0]};
    up = (m[28:0] > 29'h1000_0000) || ((m[28:0] == 29'h1000_0000) && m[29]);
    t  = {1'b0, m[52:29]} + 25'(up);
    if (t[24]) begin
      e++;
      t = t >> 1;
    end
    return {b[63], 8'(e), t[22:0]};
  endfunction

  task automatic model_beat(input logic [31:0] d, input logic sub, input logic last);
    real         s;
    logic [31:0] r;
    res_t        e;
    s = sub ? (m_acc - f2r(d)) : (m_acc + f2r(d));
    r = r2f(s);
    m_acc = f2r(r);
    if (m_cnt < (1 << CW) - 1) m_cnt++;
    if (last) begin
      e.data  = r;
      e.count = CW'(m_cnt);
      e.flags = 3'b000;
      exp_q.push_back(e);
      m_acc = 0.0;
      m_cnt = 0;
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic sub,
                       input logic last, input logic ordy, output logic acc);
    res_t r;
    in_valid = v; in_data = d; in_subtract = sub; in_last = last; out_ready = ordy;
    @(negedge clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    check("in_ready", {31'b0, in_ready}, {31'b0, !m_ov || ordy});
    if (held) check("hold_stable", out_data, held_data);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_result", 32'(exp_q.size()), 32'd1);
      else begin
        r = exp_q.pop_front();
        check("out_data", out_data, r.data);
        check("out_count", 32'(out_count), 32'(r.count));
        check("out_flags", {29'b0, out_underflow, out_overflow, out_invalid}, {29'b0, r.flags});
      end
    end
    held      = out_valid && !out_ready;
    held_data = out_data;
    acc = v && (!m_ov || ordy);
    if (m_ov && ordy) m_ov = 1'b0;
    if (acc) begin
      if (use_model) model_beat(d, sub, last);
      if (last) m_ov = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic sub, input logic last,
                           input bit rnd_ready);
    logic        acc;
    int unsigned tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      cycle(1'b1, d, sub, last, rnd_ready ? ($urandom_range(9, 0) < 7) : 1'b1, acc);
      tries++;
    end
    if (!acc) check("beat_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    logic        acc;
    int unsigned tries;
    tries = 0;
    while ((exp_q.size() != 0 || m_ov) && tries < 40) begin
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
      tries++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_subtract = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_ov = 1'b0; held = 1'b0; m_acc = 0.0; m_cnt = 0;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_flags", {29'b0, out_underflow, out_overflow, out_invalid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned   n;
    logic [31:0]   d[3];
    logic          sub[3];
    logic [31:0]   exp_data;
    logic [CW-1:0] exp_cnt;
    logic [2:0]    exp_flags;
  } vec_t;

  function automatic vec_t mk(input int unsigned n,
                              input logic [31:0] d0, input logic s0,
                              input logic [31:0] d1, input logic s1,
                              input logic [31:0] d2, input logic s2,
                              input logic [31:0] ed, input int unsigned ec,
                              input logic [2:0] ef);
    vec_t v;
    v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.sub[0] = s0; v.sub[1] = s1; v.sub[2] = s2;
    v.exp_data = ed; v.exp_cnt = CW'(ec); v.exp_flags = ef;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    logic acc;
    res_t e;

    vecs[0]  = mk(3, 32'h3F800000, 0, 32'h40000000, 0, 32'h40400000, 0, 32'h40C00000, 3, 3'b000);
    vecs[1]  = mk(2, 32'h40A00000, 0, 32'h3F800000, 1, 32'h0, 0,        32'h40800000, 2, 3'b000);
    vecs[2]  = mk(2, 32'h7F800000, 0, 32'hFF800000, 0, 32'h0, 0,        32'hFFC00000, 2, 3'b001);
    vecs[3]  = mk(2, 32'h7F7FFFFF, 0, 32'h7F7FFFFF, 0, 32'h0, 0,        32'h7F800000, 2, 3'b010);
    vecs[4]  = mk(2, 32'h7FC00000, 0, 32'h3F800000, 0, 32'h0, 0,        32'hFFC00000, 2, 3'b000);
    vecs[5]  = mk(1, 32'h7F800001, 0, 32'h0, 0, 32'h0, 0,               32'hFFC00000, 1, 3'b001);
    vecs[6]  = mk(1, 32'h40400000, 1, 32'h0, 0, 32'h0, 0,               32'hC0400000, 1, 3'b000);
    vecs[7]  = mk(2, 32'h3F800000, 0, 32'h3F800000, 1, 32'h0, 0,        32'h00000000, 2, 3'b000);
    vecs[8]  = mk(2, 32'h3F800000, 0, 32'h33800000, 0, 32'h0, 0,        32'h3F800000, 2, 3'b000);
    vecs[9]  = mk(2, 32'h3F800001, 0, 32'h33800000, 0, 32'h0, 0,        32'h3F800002, 2, 3'b000);
    vecs[10] = mk(2, 32'h00800000, 0, 32'h00000001, 1, 32'h0, 0,        32'h007FFFFF, 2, 3'b100);
    vecs[11] = mk(2, 32'h3F800000, 0, 32'h33800001, 0, 32'h0, 0,        32'h3F800001, 2, 3'b000);
    vecs[12] = mk(3, 32'h7F7FFFFF, 0, 32'h7F7FFFFF, 0, 32'h3F800000, 0, 32'h7F800000, 3, 3'b010);

    do_reset();

    // Directed table, out_ready held high so packets run back to back.
    foreach (vecs[k]) begin
      e.data = vecs[k].exp_data; e.count = vecs[k].exp_cnt; e.flags = vecs[k].exp_flags;
      exp_q.push_back(e);
      for (int unsigned b = 0; b < vecs[k].n; b++)
        send_beat(vecs[k].d[b], vecs[k].sub[b], b == vecs[k].n - 1, 0);
    end
    drain();

    // Backpressure: result held 5 cycles, next packet starts on out_ready rise.
    e.data = 32'h40400000; e.count = CW'(2); e.flags = 3'b000;
    exp_q.push_back(e);
    send_beat(32'h3F800000, 1'b0, 1'b0, 0);
    send_beat(32'h40000000, 1'b0, 1'b1, 0);
    repeat (5) cycle(1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0, acc);
    e.data = 32'h40A00000; e.count = CW'(2);
    exp_q.push_back(e);
    cycle(1'b1, 32'h40000000, 1'b0, 1'b0, 1'b1, acc);
    check("accept_on_ready", {31'b0, acc}, 32'd1);
    send_beat(32'h40400000, 1'b0, 1'b1, 0);
    drain();

    // Count saturation: 20 beats of +0 with a 4-bit counter.
    e.data = 32'h0; e.count = '1; e.flags = 3'b000;
    exp_q.push_back(e);
    for (int unsigned b = 0; b < 20; b++) send_beat(32'h0, 1'b0, b == 19, 0);
    drain();

    // Reset drops a pending result.
    send_beat(32'h40E00000, 1'b0, 1'b1, 0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    do_reset();

    // Reset mid-packet discards the partial sum.
    send_beat(32'h40400000, 1'b0, 1'b0, 0);
    send_beat(32'h40A00000, 1'b0, 1'b0, 0);
    do_reset();
    e.data = 32'h3F800000; e.count = CW'(1); e.flags = 3'b000;
    exp_q.push_back(e);
    send_beat(32'h3F800000, 1'b0, 1'b1, 0);
    drain();

    // Random packets against the real-arithmetic model.
    use_model = 1;
    for (int unsigned p = 0; p < 40; p++) begin
      int unsigned len;
      len = $urandom_range(6, 1);
      for (int unsigned b = 0; b < len; b++) begin
        if ($urandom_range(3, 0) == 0)
          cycle(1'b0, '0, 1'b0, 1'b0, ($urandom_range(9, 0) < 7), acc);
        send_beat({1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)},
                  1'($urandom), b == len - 1, 1);
      end
    end
    drain();
    use_model = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
